// File: rtl/toggle_cov_detect.sv
// Toggle-event detector for the per-group toggle coverage reporters.
// Each bit of sig produces a rise event (valid[2i]) and a fall event
// (valid[2i+1]). With FILTER=1 an event is reported only on its first
// occurrence since the last clear. The detector also keeps a count of the
// distinct events seen and a flag that is set once all of them have been seen.
module toggle_cov_detect #(
    parameter int WIDTH  = 16,
    parameter bit FILTER = 1'b1,
    localparam int CNT_W = $clog2(2*WIDTH+1)
) (
    input  logic               gbl_clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clear,
    input  logic [WIDTH-1:0]   sig,
    output logic [2*WIDTH-1:0] valid,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic               all_covered
);

    logic [WIDTH-1:0]   prev;
    logic               primed;
    logic [2*WIDTH-1:0] seen;

    logic [2*WIDTH-1:0] ev;
    logic [2*WIDTH-1:0] new_ev;
    logic [2*WIDTH-1:0] merged;
    logic [CNT_W-1:0]   merged_cnt;

    // Edge detection against the previous sample, interleaved as {fall, rise} per bit.
    always_comb begin
        ev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ev[2*i]   = ~prev[i] &  sig[i];
            ev[2*i+1] =  prev[i] & ~sig[i];
        end
        new_ev = FILTER ? (ev & ~seen) : ev;
        merged = seen | ev;
    end

    // Population count of the events recorded once this edge is included.
    always_comb begin
        merged_cnt = '0;
        for (int j = 0; j < 2*WIDTH; j++) begin
            merged_cnt = merged_cnt + CNT_W'(merged[j]);
        end
    end

    // Sample history, coverage record and registered outputs.
    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            prev        <= '0;
            primed      <= 1'b0;
            seen        <= '0;
            valid       <= '0;
            hit_cnt     <= '0;
            all_covered <= 1'b0;
        end else begin
            valid <= '0;
            if (en) begin
                prev   <= sig;
                primed <= 1'b1;
            end
            // An event on the clearing edge is dropped, never recorded.
            if (clear) begin
                seen        <= '0;
                hit_cnt     <= '0;
                all_covered <= 1'b0;
            end else if (en && primed) begin
                valid       <= new_ev;
                seen        <= merged;
                hit_cnt     <= merged_cnt;
                all_covered <= &merged;
            end
        end
    end

endmodule

// File: doc/toggle_cov_detect.md
# toggle_cov_detect

Toggle-event detector that feeds the per-group toggle coverage reporters. It samples a monitored signal vector every cycle and raises a one-cycle pulse for each bit that rises or falls. With filtering enabled, a pulse fires only the first time each event occurs since the last clear. Its `valid` output connects directly to the `valid` input of a coverage reporter of width 2*WIDTH. It also keeps a running count of distinct events hit and a full-coverage flag.

## Interface
- WIDTH, 16: number of monitored signal bits (1..512).
- FILTER, 1: 1 = report each event once until `clear`; 0 = report every occurrence.
- CNT_W (localparam) = $clog2(2*WIDTH+1): width of `hit_cnt`.

Ports:
- gbl_clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  reset, synchronous, active-low.
- en  in  1  sampling enable; low = sampling frozen.
- clear  in  1  one-cycle request to forget all recorded events.
- sig  in  WIDTH  monitored signal vector.
- valid  out  2*WIDTH  event pulses. Bit 2i = rise on sig[i]; bit 2i+1 = fall on sig[i].
- hit_cnt  out  CNT_W  number of distinct events recorded since reset or clear.
- all_covered  out  1  high when every one of the 2*WIDTH events has been recorded.

## Operation
- State:
  - `prev[WIDTH]`: last sampled value.
  - `primed`: set once `prev` holds a valid sample.
  - `seen[2*WIDTH]`: events recorded.
  - `valid`, `hit_cnt`, `all_covered`: registered outputs.
- Reset (reset==0 at an edge): prev=0, primed=0, seen=0, valid=0, hit_cnt=0, all_covered=0.
- Priming: on the first edge with en=1 after reset, prev<=sig and primed<=1. No events are generated on that edge, even if sig≠0.
- Event detection, evaluated on an edge with en=1 and primed=1:
  - rise[i] = ~prev[i] & sig[i]; fall[i] = prev[i] & ~sig[i].
  - ev = interleave(rise, fall), so ev[2i]=rise[i] and ev[2i+1]=fall[i].
  - prev<=sig.
- Filtering: new = FILTER ? ev & ~seen : ev.
- Updates on a normal edge:
  - valid <= new.
  - seen <= seen | ev.
  - hit_cnt <= popcount(seen | ev).
  - all_covered <= &(seen | ev).
- en=0: prev, primed, seen and hit_cnt hold, and valid<=0. When en returns, the first sample is compared against the held prev. A toggle that happened while disabled is reported once; glitches inside the disabled window are invisible.
- clear=1 (with en either value):
  - seen<=0, hit_cnt<=0, all_covered<=0, valid<=0.
  - Any event detected on the same edge is discarded and not recorded.
  - prev still updates if en=1; primed is unaffected.
- reset and clear together: reset wins.
- FILTER=0: `valid` reflects every event. `seen`, `hit_cnt` and `all_covered` still track distinct events.
- hit_cnt cannot overflow; its maximum is 2*WIDTH, which CNT_W is sized to hold.

## Timing
- Latency: a change on sig sampled at edge k appears on valid after edge k, for exactly one cycle. The downstream reporter consumes it at edge k+1.
- hit_cnt and all_covered update on the same edge as the corresponding valid pulse.
- Back-to-back toggles on consecutive edges produce pulses on consecutive cycles (FILTER=0). With FILTER=1, only the first pulse of each event appears.
- Simultaneous rise and fall of different bits on one edge produce multiple valid bits in the same cycle.
- No handshake or backpressure: the consumer must accept valid every cycle.
- Outputs are 0 in the cycle after any reset edge.

## Test plan
All scenarios use WIDTH=4 and FILTER=1 unless stated.
- Priming and first rise: release reset with sig=4'h3, en=1 → valid=0 after the first edge. Then sig=4'h7 → valid=8'b0001_0000 for one cycle, hit_cnt=1.
- Filtering: from primed sig=0, drive sig=1,0,1,0 on consecutive cycles:
  - FILTER=1 → valid=8'h01, then 8'h02, then 0, 0; hit_cnt settles at 2.
  - FILTER=0 → valid=8'h01, 8'h02, 8'h01, 8'h02.
- Full coverage: drive sig 4'h0→4'hF→4'h0 → valid=8'h55, then 8'hAA; hit_cnt=8; all_covered=1 on the second pulse cycle.
- Clear collision: with hit_cnt=3, assert clear on the same edge as bit2 rising (0→1) → valid=0, hit_cnt=0, all_covered=0. Next edge, bit2 falls → valid=8'b0010_0000, hit_cnt=1.
- Enable gap: with primed sig=0, set en=0; drive sig=8, then 0, then 8; set en=1 with sig=8 → exactly one pulse, valid=8'b0100_0000, on the cycle after en returns. No pulses while en=0.
- Mid-run reset: with hit_cnt=5, assert reset for one edge → valid=0, hit_cnt=0, all_covered=0. The next en=1 edge only primes (valid=0), even with sig≠prior value.
